// File: rtl/snap_tx_capture_ctrl.sv
// Purpose: arm/trigger capture controller that streams TX words into a snapshot BRAM and reports progress.
// Latency: din/we sampled on cycle N appear on bram_addr/bram_data/bram_we, with the updated count, on cycle N+1.
// Backpressure: none; words arriving after the buffer fills, or outside a capture, are dropped.
module snap_tx_capture_ctrl #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 64
) (
    input  logic              user_clk,
    input  logic              user_rst,
    input  logic [31:0]       ctrl,
    input  logic [DATA_W-1:0] din,
    input  logic              we,
    input  logic              trig,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_data,
    output logic              bram_we,
    output logic [31:0]       addr_out
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    // Count saturates at the buffer depth; LAST is the count at which the final word is written.
    localparam logic [ADDR_W:0] FULL = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] LAST = {1'b0, {ADDR_W{1'b1}}};

    state_t            state;
    logic [ADDR_W:0]   count;
    logic              ctrl0_q;
    logic              arm_edge;
    logic              start;
    logic              cap_en;
    logic              unused_ctrl_bits;

    // Upper control bits carry no meaning for this block.
    assign unused_ctrl_bits = ^ctrl[31:2];

    // Arm acts only on a 0->1 transition of ctrl[0]; trigger is external level or software bit.
    always_comb begin
        arm_edge = ctrl[0] & ~ctrl0_q;
        start    = trig | ctrl[1];
        cap_en   = 1'b0;
        // A re-arm in the same cycle always wins over capturing the word.
        if (!arm_edge && we && (count != FULL)) begin
            if (state == CAPTURE) begin
                cap_en = 1'b1;
            end else if ((state == ARMED) && start) begin
                cap_en = 1'b1;
            end
        end
    end

    // Control FSM, word counter and registered BRAM write port.
    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            state     <= IDLE;
            count     <= '0;
            ctrl0_q   <= 1'b0;
            bram_we   <= 1'b0;
            bram_addr <= '0;
            bram_data <= '0;
        end else begin
            ctrl0_q <= ctrl[0];
            bram_we <= 1'b0;

            if (arm_edge) begin
                // Arming from any state restarts the snapshot from address 0.
                state <= ARMED;
                count <= '0;
            end else begin
                if ((state == ARMED) && start) begin
                    state <= CAPTURE;
                end
                if (cap_en) begin
                    bram_we   <= 1'b1;
                    bram_addr <= count[ADDR_W-1:0];
                    bram_data <= din;
                    count     <= count + 1'b1;
                    // Writing the top address completes the snapshot.
                    if (count == LAST) begin
                        state <= DONE;
                    end
                end
            end
        end
    end

    // Status word: done flag, active flag and the number of words written.
    always_comb begin
        addr_out           = '0;
        addr_out[31]       = (state == DONE);
        addr_out[30]       = (state == ARMED) || (state == CAPTURE);
        addr_out[ADDR_W:0] = count;
    end

endmodule

// File: tb/tb_snap_tx_capture_ctrl.sv
// Purpose: directed scenarios plus randomized traffic against a behavioural capture model.
// Latency: every output is compared 1 time unit after each rising clock edge.
// Backpressure: not applicable; inputs are driven freely each cycle.
module tb_snap_tx_capture_ctrl;

    localparam int AW    = 4;
    localparam int DW    = 64;
    localparam int DEPTH = 16;

    logic          user_clk = 1'b0;
    logic          user_rst;
    logic [31:0]   ctrl;
    logic [DW-1:0] din;
    logic          we;
    logic          trig;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_data;
    logic          bram_we;
    logic [31:0]   addr_out;

    snap_tx_capture_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .user_clk  (user_clk),
        .user_rst  (user_rst),
        .ctrl      (ctrl),
        .din       (din),
        .we        (we),
        .trig      (trig),
        .bram_addr (bram_addr),
        .bram_data (bram_data),
        .bram_we   (bram_we),
        .addr_out  (addr_out)
    );

    always #5 user_clk = ~user_clk;

    int checks = 0;
    int errors = 0;

    // Reference model: phase of the snapshot, words written, last write seen.
    bit            m_armed;
    bit            m_capturing;
    bit            m_done;
    int            m_cnt;
    bit            m_prev_arm;
    bit            m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    logic [DW-1:0] exp_mem [DEPTH];
    logic [DW-1:0] dut_mem [DEPTH];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_status();
        logic [31:0] r;
        r     = 32'(m_cnt);
        r[31] = m_done;
        r[30] = m_armed | m_capturing;
        return r;
    endfunction

    task automatic model_cycle(input logic rst, input logic [31:0] c, input logic [DW-1:0] d,
                               input logic w, input logic t);
        bit arm_e;
        if (rst) begin
            m_armed = 0; m_capturing = 0; m_done = 0;
            m_cnt = 0; m_prev_arm = 0; m_we = 0; m_addr = '0; m_data = '0;
        end else begin
            arm_e      = c[0] && !m_prev_arm;
            m_prev_arm = c[0];
            m_we       = 0;
            if (arm_e) begin
                m_armed = 1; m_capturing = 0; m_done = 0; m_cnt = 0;
            end else begin
                if (m_armed && (t || c[1])) begin
                    m_armed = 0; m_capturing = 1;
                end
                if (m_capturing && w && m_cnt < DEPTH) begin
                    m_we   = 1;
                    m_addr = AW'(m_cnt);
                    m_data = d;
                    exp_mem[m_cnt] = d;
                    m_cnt++;
                    if (m_cnt == DEPTH) begin
                        m_capturing = 0; m_done = 1;
                    end
                end
            end
        end
    endtask

    task automatic step(input logic rst, input logic [31:0] c, input logic [DW-1:0] d,
                        input logic w, input logic t);
        user_rst = rst; ctrl = c; din = d; we = w; trig = t;
        @(posedge user_clk);
        model_cycle(rst, c, d, w, t);
        #1;
        if (bram_we === 1'b1) dut_mem[bram_addr] = bram_data;
        chk("bram_we", bram_we, m_we);
        chk("bram_addr", bram_addr, m_addr);
        chk("bram_data", bram_data, m_data);
        chk("addr_out", addr_out, model_status());
    endtask

    task automatic clear_mems();
        for (int i = 0; i < DEPTH; i++) begin
            exp_mem[i] = '0;
            dut_mem[i] = '0;
        end
    endtask

    task automatic cmp_mems(input string tag);
        for (int i = 0; i < DEPTH; i++) begin
            chk($sformatf("%s_mem%0d", tag, i), dut_mem[i], exp_mem[i]);
        end
    endtask

    initial begin
        logic [31:0] c;
        logic        arm_lvl;
        clear_mems();

        // Reset with we/trig toggling.
        for (int i = 0; i < 4; i++) step(1'b1, $urandom, {$urandom, $urandom}, i[0], ~i[0]);
        chk("rst_status", addr_out, 32'h0);
        chk("rst_we", bram_we, 1'b0);
        step(1'b0, 32'h0, 64'h0, 1'b0, 1'b0);

        // Trigger while idle does nothing.
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 64'(i + 77), 1'b1, 1'b1);
        chk("idle_trig_status", addr_out, 32'h0);

        // Arm, then external trigger with five words.
        clear_mems();
        step(1'b0, 32'h1, 64'h0, 1'b0, 1'b0);
        chk("armed_status", addr_out, 32'h4000_0000);
        for (int i = 1; i <= 5; i++) step(1'b0, 32'h1, 64'(i), 1'b1, 1'b1);
        step(1'b0, 32'h1, 64'h0, 1'b0, 1'b0);
        chk("five_status", addr_out, 32'h4000_0005);
        for (int i = 0; i < 5; i++) chk("five_word", dut_mem[i], 64'(i + 1));

        // Software trigger with 20 words: only 16 land.
        step(1'b0, 32'h0, 64'h0, 1'b0, 1'b0);
        clear_mems();
        step(1'b0, 32'h1, 64'h0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b0, 32'h3, 64'(100 + i), 1'b1, 1'b0);
        chk("full_status", addr_out, 32'h8000_0010);
        chk("full_last_word", dut_mem[15], 64'd115);
        cmp_mems("full");

        // Arm held high in DONE plus triggers: no re-arm, no writes.
        for (int i = 0; i < 5; i++) step(1'b0, 32'h1, {$urandom, $urandom}, 1'b1, 1'b1);
        chk("done_hold_status", addr_out, 32'h8000_0010);

        // Alternating we during capture.
        step(1'b0, 32'h0, 64'h0, 1'b0, 1'b0);
        clear_mems();
        step(1'b0, 32'h1, 64'h0, 1'b0, 1'b0);
        step(1'b0, 32'h1, 64'h0, 1'b0, 1'b1);
        for (int i = 0; i < 12; i++) step(1'b0, 32'h1, 64'(200 + i), (i % 2) == 0, 1'b0);
        chk("alt_status", addr_out, 32'h4000_0006);
        cmp_mems("alt");

        // Re-arm after seven words.
        step(1'b0, 32'h0, 64'h0, 1'b0, 1'b0);
        clear_mems();
        step(1'b0, 32'h1, 64'h0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b0, 32'h1, 64'(300 + i), 1'b1, 1'b1);
        chk("seven_status", addr_out, 32'h4000_0007);
        step(1'b0, 32'h0, 64'h0, 1'b0, 1'b0);
        step(1'b0, 32'h1, 64'd999, 1'b1, 1'b1);
        chk("rearm_status", addr_out, 32'h4000_0000);
        chk("rearm_no_write", bram_we, 1'b0);
        step(1'b0, 32'h1, 64'd500, 1'b1, 1'b1);
        chk("restart_addr", bram_addr, 4'd0);
        chk("restart_data", bram_data, 64'd500);

        // Randomized traffic with occasional resets and re-arms.
        arm_lvl = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 19) == 0) arm_lvl = ~arm_lvl;
            c    = $urandom & 32'hFFFF_FFFC;
            c[0] = arm_lvl;
            c[1] = ($urandom_range(0, 7) == 0);
            step($urandom_range(0, 199) == 0, c, {$urandom, $urandom},
                 $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0);
        end
        cmp_mems("rand");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
